// File: rtl/vt52_pkg.sv
// rtl/vt52_pkg.sv - shared key codes, escape constants and encoder types
package vt52_pkg;

    localparam logic [7:0] KEY_UP    = 8'h80;
    localparam logic [7:0] KEY_DOWN  = 8'h81;
    localparam logic [7:0] KEY_RIGHT = 8'h82;
    localparam logic [7:0] KEY_LEFT  = 8'h83;
    localparam logic [7:0] KEY_PF1   = 8'h84;
    localparam logic [7:0] KEY_PF2   = 8'h85;
    localparam logic [7:0] KEY_PF3   = 8'h86;
    localparam logic [7:0] KEY_KP0   = 8'h90;
    localparam logic [7:0] KEY_KP9   = 8'h99;

    localparam logic [7:0] ESC_DEFAULT         = 8'h1B;
    localparam logic [7:0] IDENT_FINAL_DEFAULT = 8'h4B;
    localparam logic [7:0] IDENT_MID           = 8'h2F;
    localparam logic [7:0] CURSOR_BASE         = 8'h41;
    localparam logic [7:0] PF_BASE             = 8'h50;
    localparam logic [7:0] KP_NUM_BASE         = 8'h30;
    localparam logic [7:0] KP_ALT_PREFIX       = 8'h3F;
    localparam logic [7:0] KP_ALT_BASE         = 8'h70;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2,
        SEND2 = 2'd3
    } state_t;

    // bytes[0] goes out first; len of 0 means the key produces no output
    typedef struct packed {
        logic [1:0]      len;
        logic [2:0][7:0] bytes;
    } key_seq_t;

endpackage

// File: rtl/vt52_key_lut.sv
// rtl/vt52_key_lut.sv - combinational key code to VT52 byte sequence
module vt52_key_lut
    import vt52_pkg::*;
#(
    parameter logic [7:0] ESC_CODE = ESC_DEFAULT
) (
    input  logic [7:0] i_key_code,
    input  logic       i_alt_keypad,
    output key_seq_t   o_seq
);

    logic [7:0] w_cur_off;
    logic [7:0] w_pf_off;
    logic [7:0] w_kp_off;

    assign w_cur_off = i_key_code - KEY_UP;
    assign w_pf_off  = i_key_code - KEY_PF1;
    assign w_kp_off  = i_key_code - KEY_KP0;

    always_comb begin
        o_seq = '0;
        if (!i_key_code[7]) begin
            o_seq.len      = 2'd1;
            o_seq.bytes[0] = i_key_code;
        end else if (i_key_code >= KEY_UP && i_key_code <= KEY_LEFT) begin
            o_seq.len      = 2'd2;
            o_seq.bytes[0] = ESC_CODE;
            o_seq.bytes[1] = CURSOR_BASE + w_cur_off;
        end else if (i_key_code >= KEY_PF1 && i_key_code <= KEY_PF3) begin
            o_seq.len      = 2'd2;
            o_seq.bytes[0] = ESC_CODE;
            o_seq.bytes[1] = PF_BASE + w_pf_off;
        end else if (i_key_code >= KEY_KP0 && i_key_code <= KEY_KP9) begin
            if (i_alt_keypad) begin
                o_seq.len      = 2'd3;
                o_seq.bytes[0] = ESC_CODE;
                o_seq.bytes[1] = KP_ALT_PREFIX;
                o_seq.bytes[2] = KP_ALT_BASE + w_kp_off;
            end else begin
                o_seq.len      = 2'd1;
                o_seq.bytes[0] = KP_NUM_BASE + w_kp_off;
            end
        end
    end

endmodule

// File: rtl/vt52_key_encoder.sv
// rtl/vt52_key_encoder.sv - VT52 keyboard encoder: key events and identify
// requests serialised into byte sequences for the UART transmitter.
module vt52_key_encoder
    import vt52_pkg::*;
#(
    parameter logic [7:0] IDENT_FINAL = IDENT_FINAL_DEFAULT,
    parameter logic [7:0] ESC_CODE    = ESC_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_code,
    output logic       o_key_ready,
    input  logic       i_ident_req,
    input  logic       i_alt_keypad,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready
);

    state_t     r_state, w_state_nxt;
    key_seq_t   r_seq, w_seq_nxt;
    key_seq_t   w_key_seq;
    key_seq_t   w_ident_seq;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic       r_tx_valid, w_tx_valid_nxt;
    logic       r_ident_pending, w_ident_pending_nxt;
    logic       r_ident_active, w_ident_active_nxt;
    logic       w_xfer;
    logic       w_load_ident;

    vt52_key_lut #(
        .ESC_CODE (ESC_CODE)
    ) u_lut (
        .i_key_code   (i_key_code),
        .i_alt_keypad (i_alt_keypad),
        .o_seq        (w_key_seq)
    );

    assign w_ident_seq.len   = 2'd3;
    assign w_ident_seq.bytes = {IDENT_FINAL, IDENT_MID, ESC_CODE};

    assign w_xfer      = r_tx_valid && i_tx_ready;
    assign o_key_ready = (r_state == IDLE) && !r_ident_pending;
    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;

    always_comb begin
        w_state_nxt        = r_state;
        w_seq_nxt          = r_seq;
        w_tx_data_nxt      = r_tx_data;
        w_tx_valid_nxt     = r_tx_valid;
        w_ident_active_nxt = r_ident_active;
        w_load_ident       = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_valid_nxt = 1'b0;
                if (r_ident_pending) begin
                    w_load_ident       = 1'b1;
                    w_ident_active_nxt = 1'b1;
                    w_seq_nxt          = w_ident_seq;
                    w_tx_data_nxt      = w_ident_seq.bytes[0];
                    w_tx_valid_nxt     = 1'b1;
                    w_state_nxt        = SEND0;
                end else if (i_key_valid && w_key_seq.len != 2'd0) begin
                    w_seq_nxt      = w_key_seq;
                    w_tx_data_nxt  = w_key_seq.bytes[0];
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = SEND0;
                end
            end
            SEND0: begin
                if (w_xfer) begin
                    if (r_seq.len > 2'd1) begin
                        w_tx_data_nxt = r_seq.bytes[1];
                        w_state_nxt   = SEND1;
                    end else begin
                        w_tx_valid_nxt     = 1'b0;
                        w_ident_active_nxt = 1'b0;
                        w_state_nxt        = IDLE;
                    end
                end
            end
            SEND1: begin
                if (w_xfer) begin
                    if (r_seq.len > 2'd2) begin
                        w_tx_data_nxt = r_seq.bytes[2];
                        w_state_nxt   = SEND2;
                    end else begin
                        w_tx_valid_nxt     = 1'b0;
                        w_ident_active_nxt = 1'b0;
                        w_state_nxt        = IDLE;
                    end
                end
            end
            SEND2: begin
                if (w_xfer) begin
                    w_tx_valid_nxt     = 1'b0;
                    w_ident_active_nxt = 1'b0;
                    w_state_nxt        = IDLE;
                end
            end
            default: begin
                w_tx_valid_nxt     = 1'b0;
                w_ident_active_nxt = 1'b0;
                w_state_nxt        = IDLE;
            end
        endcase
        // Requests arriving while one is queued or on the wire fold into it.
        w_ident_pending_nxt = !w_load_ident &&
                              (r_ident_pending || (i_ident_req && !r_ident_active));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_seq           <= '0;
            r_tx_data       <= 8'h00;
            r_tx_valid      <= 1'b0;
            r_ident_pending <= 1'b0;
            r_ident_active  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_seq           <= w_seq_nxt;
            r_tx_data       <= w_tx_data_nxt;
            r_tx_valid      <= w_tx_valid_nxt;
            r_ident_pending <= w_ident_pending_nxt;
            r_ident_active  <= w_ident_active_nxt;
        end
    end

endmodule

// File: tb/tb_vt52_key_encoder.sv
// tb/tb_vt52_key_encoder.sv - self-checking bench for vt52_key_encoder
module tb_vt52_key_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic       ident_req;
    logic       alt_keypad;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       mon_en;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ident_left;
    logic       lat_due;
    logic       hold_due;
    logic [7:0] hold_data;

    always #5 clk = ~clk;

    vt52_key_encoder dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_key_valid  (key_valid),
        .i_key_code   (key_code),
        .o_key_ready  (key_ready),
        .i_ident_req  (ident_req),
        .i_alt_keypad (alt_keypad),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_byte(input logic ident, input logic [7:0] b);
        exp_q.push_back({ident, b});
    endfunction

    // Reference encoding taken straight from the VT52 key table.
    function automatic void push_key(input logic [7:0] code, input logic alt);
        string arrows    = "ABCD";
        string pfs       = "PQR";
        string digits    = "0123456789";
        string alt_final = "pqrstuvwxy";
        int    c         = int'(code);
        if (c < 'h80) begin
            push_byte(1'b0, code);
        end else if (c <= 'h83) begin
            push_byte(1'b0, 8'h1B);
            push_byte(1'b0, arrows[c - 'h80]);
        end else if (c <= 'h86) begin
            push_byte(1'b0, 8'h1B);
            push_byte(1'b0, pfs[c - 'h84]);
        end else if (c >= 'h90 && c <= 'h99) begin
            if (alt) begin
                push_byte(1'b0, 8'h1B);
                push_byte(1'b0, "?");
                push_byte(1'b0, alt_final[c - 'h90]);
            end else begin
                push_byte(1'b0, digits[c - 'h90]);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            exp_q.delete();
            ident_left = 0;
            lat_due    = 1'b0;
            hold_due   = 1'b0;
        end else begin
            logic take_ident;
            logic [8:0] e;
            int n;
            check("key_ready", int'(key_ready), int'(exp_q.size() == 0));
            if (lat_due) check("first_byte_latency", int'(tx_valid), 1);
            if (hold_due) begin
                check("stall_valid", int'(tx_valid), 1);
                check("stall_data", int'(tx_data), int'(hold_data));
            end
            take_ident = ident_req && (ident_left == 0);
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(tx_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", int'(tx_data), int'(e[7:0]));
                    if (e[8]) ident_left--;
                end
            end
            hold_due  = tx_valid && !tx_ready;
            hold_data = tx_data;
            lat_due   = 1'b0;
            if (key_valid && key_ready) begin
                n = exp_q.size();
                push_key(key_code, alt_keypad);
                lat_due = exp_q.size() > n;
            end
            if (take_ident) begin
                push_byte(1'b1, 8'h1B);
                push_byte(1'b1, "/");
                push_byte(1'b1, "K");
                ident_left = 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (key_ready && !tx_valid) return;
            tick();
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic send_key(input logic [7:0] code, input logic alt);
        key_valid  = 1'b1;
        key_code   = code;
        alt_keypad = alt;
        for (int i = 0; i < 400; i++) begin
            if (key_ready) begin
                tick();
                key_valid  = 1'b0;
                alt_keypad = ~alt;
                return;
            end
            tick();
        end
        key_valid = 1'b0;
        check("accept_timeout", 0, 1);
    endtask

    task automatic expect_bytes(input string tag, input int start, input logic [39:0] exp, input int n);
        check({tag, "_count"}, got_q.size() - start, n);
        for (int i = 0; i < n; i++) begin
            if (start + i < got_q.size())
                check(tag, int'(got_q[start + i]), int'(exp[8 * (n - 1 - i) +: 8]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        reset      = 1'b1;
        mon_en     = 1'b0;
        key_valid  = 1'b0;
        key_code   = 8'h00;
        ident_req  = 1'b0;
        alt_keypad = 1'b0;
        tx_ready   = 1'b1;
        tick();
        check("reset_tx_valid", int'(tx_valid), 0);
        check("reset_tx_data", int'(tx_data), 0);
        tick();
        reset = 1'b0;
        check("key_ready_after_reset", int'(key_ready), 1);
        mon_en = 1'b1;

        // plain ASCII byte
        start     = got_q.size();
        key_valid = 1'b1;
        key_code  = 8'h41;
        tick();
        key_valid = 1'b0;
        check("ascii_valid", int'(tx_valid), 1);
        check("ascii_data", int'(tx_data), 'h41);
        check("ascii_busy", int'(key_ready), 0);
        tick();
        check("ascii_ready_again", int'(key_ready), 1);
        expect_bytes("ascii_seq", start, 40'h41, 1);

        // cursor up with the second byte stalled
        start = got_q.size();
        send_key(8'h80, 1'b0);
        check("up_first", int'(tx_data), 'h1B);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("up_stall_data", int'(tx_data), 'h41);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle();
        expect_bytes("up_seq", start, 40'h1B41, 2);

        // keypad 3, alternate then numeric mode
        start = got_q.size();
        send_key(8'h93, 1'b1);
        wait_idle();
        expect_bytes("kp3_alt", start, 40'h1B3F73, 3);
        start = got_q.size();
        send_key(8'h93, 1'b0);
        wait_idle();
        expect_bytes("kp3_num", start, 40'h33, 1);

        // identify together with a key, plus repeats that must merge
        start     = got_q.size();
        key_valid = 1'b1;
        key_code  = 8'h82;
        ident_req = 1'b1;
        tick();
        key_valid = 1'b0;
        ident_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ident_req = (i == 2 || i == 4);
            tick();
        end
        ident_req = 1'b0;
        wait_idle();
        expect_bytes("ident_merge", start, 40'h1B431B2F4B, 5);

        // reset in the middle of an identify response
        start     = got_q.size();
        ident_req = 1'b1;
        tick();
        ident_req = 1'b0;
        tick();
        tick();
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("reset_async_valid", int'(tx_valid), 0);
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("reset_no_resume", int'(tx_valid), 0);
        expect_bytes("ident_cut", start, 40'h1B, 1);
        start = got_q.size();
        send_key(8'h8F, 1'b0);
        check("unused_no_valid", int'(tx_valid), 0);
        check("unused_ready", int'(key_ready), 1);
        tick();
        check("unused_no_bytes", got_q.size() - start, 0);

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            tx_ready   = ((c % 500) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
            alt_keypad = 1'($urandom_range(0, 1));
            ident_req  = ($urandom_range(0, 30) == 0);
            key_valid  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       key_code = 8'($urandom_range(0, 'h7F));
                1:       key_code = 8'($urandom_range('h80, 'h86));
                2:       key_code = 8'($urandom_range('h90, 'h99));
                3:       key_code = 8'($urandom_range(0, 'hFF));
                default: key_code = 8'($urandom_range('h87, 'h8F));
            endcase
            tick();
        end
        key_valid = 1'b0;
        ident_req = 1'b0;
        tx_ready  = 1'b1;
        wait_idle();
        tick();
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
